// File: rtl/usb_tx_sched.sv
// Transmit scheduler: arbitrates handshake and data requests and sequences each
// grant into a complete FS packet (PID, payload, CRC16) on the UTMI tx port.
module usb_tx_sched #(
  parameter int IFG = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs_req,
  input  logic [3:0] hs_pid,
  output logic       hs_ack,
  input  logic       dat_req,
  input  logic [3:0] dat_pid,
  input  logic       dat_zlp,
  input  logic [7:0] dat_data,
  input  logic       dat_valid,
  input  logic       dat_last,
  output logic       dat_ready,
  output logic       dat_done,
  output logic       dat_err,
  output logic [7:0] utmi_data_in,
  output logic       utmi_tx_valid,
  input  logic       utmi_tx_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_GAP
  } state_e;

  localparam logic [3:0] GAP_LOAD = 4'(IFG - 1);

  state_e      state_q, state_d;
  logic        is_hs_q, is_hs_d;
  logic [3:0]  pid_q, pid_d;
  logic        zlp_q, zlp_d;
  logic [15:0] crc_q, crc_d;
  logic [3:0]  gap_q, gap_d;
  logic        tx_valid_q, tx_valid_d;
  logic        hs_ack_q, hs_ack_d;
  logic        dat_done_q, dat_done_d;
  logic        dat_err_q, dat_err_d;
  logic        xfer;

  // Reflected form of the 0x8005 CRC: shifting right consumes each byte LSB
  // first, and the low register byte is the first one on the wire.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  assign xfer          = tx_valid_q && utmi_tx_ready;
  assign utmi_tx_valid = tx_valid_q;
  assign hs_ack        = hs_ack_q;
  assign dat_done      = dat_done_q;
  assign dat_err       = dat_err_q;
  assign busy          = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    is_hs_d      = is_hs_q;
    pid_d        = pid_q;
    zlp_d        = zlp_q;
    crc_d        = crc_q;
    gap_d        = gap_q;
    hs_ack_d     = 1'b0;
    dat_done_d   = 1'b0;
    dat_err_d    = 1'b0;
    utmi_data_in = 8'h00;
    dat_ready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hs_req) begin
          is_hs_d = 1'b1;
          pid_d   = hs_pid;
          zlp_d   = 1'b0;
          crc_d   = 16'hFFFF;
          state_d = S_PID;
        end else if (dat_req) begin
          is_hs_d = 1'b0;
          pid_d   = dat_pid;
          zlp_d   = dat_zlp;
          crc_d   = 16'hFFFF;
          state_d = S_PID;
        end
      end
      S_PID: begin
        utmi_data_in = {~pid_q, pid_q};
        if (xfer) begin
          if (is_hs_q) begin
            hs_ack_d = 1'b1;
            gap_d    = GAP_LOAD;
            state_d  = S_GAP;
          end else if (zlp_q) begin
            state_d = S_CRC_LO;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        utmi_data_in = dat_data;
        dat_ready    = utmi_tx_ready && dat_valid;
        if (dat_ready) begin
          crc_d = crc16_byte(crc_q, dat_data);
          if (dat_last) state_d = S_CRC_LO;
        end else if (utmi_tx_ready) begin
          // Source starved while the PHY wanted a byte: abandon the packet.
          dat_err_d = 1'b1;
          gap_d     = GAP_LOAD;
          state_d   = S_GAP;
        end
      end
      S_CRC_LO: begin
        utmi_data_in = ~crc_q[7:0];
        if (xfer) state_d = S_CRC_HI;
      end
      S_CRC_HI: begin
        utmi_data_in = ~crc_q[15:8];
        if (xfer) begin
          dat_done_d = 1'b1;
          gap_d      = GAP_LOAD;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    tx_valid_d = (state_d == S_PID) || (state_d == S_DATA) ||
                 (state_d == S_CRC_LO) || (state_d == S_CRC_HI);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      is_hs_q    <= 1'b0;
      pid_q      <= 4'h0;
      zlp_q      <= 1'b0;
      crc_q      <= 16'hFFFF;
      gap_q      <= 4'd0;
      tx_valid_q <= 1'b0;
      hs_ack_q   <= 1'b0;
      dat_done_q <= 1'b0;
      dat_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_hs_q    <= is_hs_d;
      pid_q      <= pid_d;
      zlp_q      <= zlp_d;
      crc_q      <= crc_d;
      gap_q      <= gap_d;
      tx_valid_q <= tx_valid_d;
      hs_ack_q   <= hs_ack_d;
      dat_done_q <= dat_done_d;
      dat_err_q  <= dat_err_d;
    end
  end

endmodule

// File: doc/usb_tx_sched.md
# usb_tx_sched

Transmit-side packet scheduler between the device's packet sources and the UTMI transmit port. It arbitrates two requesters and sequences each granted request into a complete USB 2.0 FS packet on the UTMI `data_in` / `tx_valid` / `tx_ready` handshake:

- a handshake generator (ACK/NAK/STALL);
- an endpoint data source (DATA0/DATA1 with payload).

For data packets it generates the PID byte, streams the payload and appends the CRC16.

## Interface

Parameters:
- `IFG`, default 2: idle cycles forced on `utmi_tx_valid` between packets; legal range 1..15.

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `hs_req`  in  1  handshake packet request; held until `hs_ack`
- `hs_pid`  in  4  handshake PID nibble (ACK 0x2, NAK 0xA, STALL 0xE); stable while `hs_req`
- `hs_ack`  out  1  one-cycle pulse when the handshake PID byte is accepted
- `dat_req`  in  1  data packet request; held until `dat_done` or `dat_err`
- `dat_pid`  in  4  DATA0 0x3 / DATA1 0xB; stable while `dat_req`
- `dat_zlp`  in  1  zero-length packet; sampled at grant
- `dat_data`  in  8  payload byte
- `dat_valid`  in  1  payload byte valid
- `dat_last`  in  1  qualifies the final payload byte
- `dat_ready`  out  1  payload byte consumed this cycle
- `dat_done`  out  1  one-cycle pulse when CRC high byte is accepted
- `dat_err`  out  1  one-cycle pulse on payload underrun abort
- `utmi_data_in`  out  8  byte to UTMI
- `utmi_tx_valid`  out  1  UTMI transmit valid
- `utmi_tx_ready`  in  1  UTMI accepts the current byte
- `busy`  out  1  high in every state except IDLE

## Operation

- **Reset:** with `rst` low, all outputs are 0, state is IDLE, the CRC register is 0xFFFF and the gap counter is 0.
- **States:** IDLE, PID, DATA, CRC_LO, CRC_HI, GAP.
- **Byte transfer:** a byte transfers on a cycle with `utmi_tx_valid && utmi_tx_ready`.
- **IDLE:**
  - Arbitration is fixed priority: `hs_req` wins over `dat_req`.
  - The grant latches the winner, its PID and `dat_zlp`, then moves to PID.
  - Requests are sampled only in IDLE; a request that arrives mid-packet waits.
- **PID:** `utmi_data_in = {~pid, pid}`. On transfer:
  - handshake: pulse `hs_ack`, go to GAP;
  - data with ZLP: go to CRC_LO;
  - data otherwise: go to DATA.
- **DATA:**
  - `utmi_data_in = dat_data` (combinational).
  - `dat_ready = utmi_tx_ready && dat_valid`.
  - CRC updates on each `dat_ready` byte.
  - On a `dat_ready` byte with `dat_last` high: go to CRC_LO.
- **Underrun:** in DATA, `utmi_tx_ready` high while `dat_valid` low means underrun:
  - drop `utmi_tx_valid` next cycle (UTMI ends the packet; the host discards it on bad CRC);
  - pulse `dat_err`;
  - go to GAP.
- **CRC16:**
  - polynomial 0x8005, initialized to 0xFFFF at grant;
  - each byte is processed LSB first;
  - transmitted value is the bitwise complement of the register;
  - CRC_LO sends bits [7:0], CRC_HI sends bits [15:8];
  - on the CRC_HI transfer, pulse `dat_done` and go to GAP.
- **GAP:** `utmi_tx_valid = 0` for `IFG` cycles, then IDLE.
- **Valid hold rule:** `utmi_tx_valid` is high continuously from PID entry through the last byte. It is never deasserted mid-packet except on underrun abort.
- **Reset mid-packet:** asynchronous return to reset values. No completion or error pulse is emitted, and requests are re-arbitrated after reset release.

## Timing

- `hs_req` or `dat_req` seen in IDLE at cycle N: state is PID and `utmi_tx_valid` = 1 at cycle N+1. `utmi_tx_valid` is registered from the state.
- Byte accepted at cycle M: the next byte is presented at M+1. With `utmi_tx_ready` held high, a packet occupies one byte per cycle.
- `hs_ack` and `dat_done` are registered and high at the cycle after the accepting cycle.
- Handshake packet, `tx_ready` always 1: `busy` spans 1 (PID) + `IFG` cycles.
- Data packet of L payload bytes, `tx_ready` always 1: L + 3 valid cycles, then `IFG` gap cycles.
- `utmi_tx_ready` low: the current byte and `utmi_data_in` hold, and the CRC does not advance.
- Back-to-back requests: the next grant occurs no earlier than `IFG` + 1 cycles after the last byte.

## Test plan

- **ACK handshake:** `hs_req`=1, `hs_pid`=0x2, `tx_ready`=1 → single byte 0xD2, `hs_ack` one pulse, `utmi_tx_valid` low for 2 cycles, `busy` low afterwards.
- **DATA0 ZLP:** `dat_req`, `dat_pid`=0x3, `dat_zlp`=1 → bytes 0xC3, 0x00, 0x00, then `dat_done`.
- **DATA1 payload with stalls:** payload 0x00 0x01 0x02 0x03, `tx_ready` toggling 1/0 → bytes 0x4B 00 01 02 03 followed by CRC matching the bench CRC16 model (low byte first). Checks: `utmi_tx_valid` never drops mid-packet; `dat_ready` pulses exactly 4 times.
- **Simultaneous requests:** `hs_req`(NAK 0xA) and `dat_req` in the same cycle → 0x5A sent first, exactly 2 gap cycles, then the data packet.
- **Underrun:** `dat_valid` deasserted after 2 of 4 payload bytes while `tx_ready`=1 → `utmi_tx_valid` falls next cycle, `dat_err` pulses, no `dat_done`, block returns to IDLE after `IFG` cycles.
- **Reset mid-packet:** `rst` low during DATA → all outputs 0 immediately; after release a new `hs_req` yields a correct 0xD2 packet.
